// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI master of the RAM-bridge link.
//   FRAME_W / DATA_W : command frame width and response byte width.
//   OP_*             : opcode values carried in cmd_data[9:8].
//   state_t          : master FSM state encoding.
package spi_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_SHIFT,
      S_WAIT,
      S_READ,
      S_GAP
   } state_t;

endpackage

// File: rtl/spi_master_shreg.sv
// spi_master_shreg -- datapath registers of the SPI master.
//   Parallel-load / serial-out frame register (MSB first) and a serial-in
//   capture register for the reply byte.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load, load_data     load the frame register with a new command
//   shift               shift the frame register left by one
//   msb                 current MSB of the frame register (next MOSI bit)
//   capture, sin        shift sin into the capture register
//   rx_next             capture register contents including the bit now on sin,
//                       so the owner can grab the full byte on the last sample
module spi_master_shreg
   import spi_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [FRAME_W-1:0] load_data,
   input  logic               shift,
   output logic               msb,
   input  logic               capture,
   input  logic               sin,
   output logic [DATA_W-1:0]  rx_next
);

   logic [FRAME_W-1:0] shreg;
   logic [DATA_W-1:0]  rx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
      end else if (load) begin
         shreg <= load_data;
      end else if (shift) begin
         shreg <= {shreg[FRAME_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx <= '0;
      end else if (capture) begin
         rx <= rx_next;
      end
   end

   assign msb     = shreg[FRAME_W-1];
   assign rx_next = {rx[DATA_W-2:0], sin};

endmodule

// File: rtl/spi_master.sv
// spi_master -- serialises 10-bit command frames MSB-first on MOSI under SS_n
// and, for rd-data frames, samples an 8-bit reply from MISO. One bit per clk;
// no separate SCK.
// Parameters:
//   RD_WAIT   cycles between last MOSI bit and first MISO sample (1..15)
//   IDLE_GAP  minimum SS_n-high cycles between frames (1..15)
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cmd_valid/ready/data  command port ([9:8] opcode, [7:0] payload)
//   rsp_valid, rsp_data   one-cycle response pulse, data held until next pulse
//   busy                  frame or gap in progress
//   err                   one-cycle protocol-violation pulse
//   SS_n, MOSI, MISO      serial link
// Build option SPI_MASTER_ADDR_TRACK_EN: rd-data commands without a preceding
// rd-addr are consumed, not sent, and flagged on err. Undefined: err is 0.
module spi_master
   import spi_pkg::*;
#(
   parameter int RD_WAIT  = 2,
   parameter int IDLE_GAP = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [FRAME_W-1:0] cmd_data,
   output logic               rsp_valid,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               busy,
   output logic               err,
   output logic               SS_n,
   output logic               MOSI,
   input  logic               MISO
);

   localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
   localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);
   localparam logic [3:0] READ_LAST  = 4'(DATA_W - 1);
   localparam logic [3:0] GAP_LAST   = 4'(IDLE_GAP - 1);

   state_t              state, state_nxt;
   logic [3:0]          cnt;
   logic                cnt_clr;
   logic [1:0]          op;
   logic                accept, drop;
   logic                load, shift, capture, msb;
   logic                rsp_fire;
   logic [DATA_W-1:0]   rx_next;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign accept    = cmd_valid && cmd_ready;

`ifdef SPI_MASTER_ADDR_TRACK_EN
   logic addr_pending;

   // rd-data is only meaningful after a rd-addr has set up the slave pointer
   assign drop = accept && (cmd_data[9:8] == OP_RD_DATA) && !addr_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_pending <= 1'b0;
      end else if (accept) begin
         if (cmd_data[9:8] == OP_RD_ADDR)      addr_pending <= 1'b1;
         else if (cmd_data[9:8] == OP_RD_DATA) addr_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else        err <= drop;
   end
`else
   assign drop = 1'b0;
   assign err  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      load      = 1'b0;
      rsp_fire  = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept && !drop) begin
               load      = 1'b1;
               state_nxt = S_LEAD;
            end
         end
         S_LEAD: begin
            cnt_clr   = 1'b1;
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt == SHIFT_LAST) begin
               cnt_clr   = 1'b1;
               state_nxt = (op == OP_RD_DATA) ? S_WAIT : S_GAP;
            end
         end
         S_WAIT: begin
            if (cnt == WAIT_LAST) begin
               cnt_clr   = 1'b1;
               state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (cnt == READ_LAST) begin
               cnt_clr   = 1'b1;
               rsp_fire  = 1'b1;
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // The pins are registered from the next state, so they line up with the
   // state being entered rather than lagging it by a cycle.
   assign shift   = (state_nxt == S_SHIFT);
   assign capture = (state == S_READ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (cnt_clr) cnt <= '0;
      else cnt <= cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    op <= OP_WR_ADDR;
      else if (load) op <= cmd_data[9:8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         SS_n      <= (state_nxt == S_IDLE) || (state_nxt == S_GAP);
         MOSI      <= shift ? msb : 1'b0;
         rsp_valid <= rsp_fire;
         if (rsp_fire) rsp_data <= rx_next;
      end
   end

   spi_master_shreg u_shreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (cmd_data),
      .shift     (shift),
      .msb       (msb),
      .capture   (capture),
      .sin       (MISO),
      .rx_next   (rx_next)
   );

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- self-checking bench for spi_master.
// Two instances: u_dut0 with default RD_WAIT=2/IDLE_GAP=1, u_dut1 with
// RD_WAIT=1/IDLE_GAP=3. Frames are checked cycle by cycle against the timing
// derived from the accept edge; replies go through a per-instance scoreboard.
module tb_spi_master;

   typedef struct {
      logic [9:0] cmd;
      logic [7:0] miso_byte;
      logic       exp_rsp;
      logic [7:0] exp_data;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] cmd_valid, cmd_ready, rsp_valid, busy, err, ss_n, mosi, miso;
   logic [9:0] cmd_data [2];
   logic [7:0] rsp_data [2];

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb0[$];
   exp_t sb1[$];

   spi_master #(.RD_WAIT(2), .IDLE_GAP(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
      .busy(busy[0]), .err(err[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
   );

   spi_master #(.RD_WAIT(1), .IDLE_GAP(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
      .busy(busy[1]), .err(err[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard: every rsp_valid pulse must match the oldest pushed entry in
   // both data and the cycle it was predicted for.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid[0]) begin
         if (sb0.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected0: got rsp %0h expected none", rsp_data[0]);
         end else begin
            e = sb0.pop_front();
            chk("rsp_data0", rsp_data[0], e.data);
            chk("rsp_cycle0", cyc, e.cyc);
         end
      end
      if (rsp_valid[1]) begin
         if (sb1.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected1: got rsp %0h expected none", rsp_data[1]);
         end else begin
            e = sb1.pop_front();
            chk("rsp_data1", rsp_data[1], e.data);
            chk("rsp_cycle1", cyc, e.cyc);
         end
      end
   end

   task automatic wait_ready(input int d);
      int n = 0;
      while (!cmd_ready[d] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++; failures++;
         $display("FAIL ready_timeout%0d: got busy expected cmd_ready", d);
      end
   endtask

   // Offer one command and check every cycle of the frame up to cmd_ready.
   // Step k is observed at the negedge following edge T+k-1.
   task automatic check_frame(input int d, input logic [9:0] c, input logic [7:0] sb,
                              input logic exp_rsp, input logic [7:0] exp_data,
                              input int rw, input int gap);
      logic is_rd;
      int   last, tcyc, idx;
      exp_t e;
      is_rd = (c[9:8] == 2'b11);
      last  = is_rd ? 20 + rw + gap : 12 + gap;
      @(negedge clk);
      cmd_valid[d] = 1'b1;
      cmd_data[d]  = c;
      wait_ready(d);
      @(negedge clk);
      cmd_valid[d] = 1'b0;
      tcyc = cyc;
      if (exp_rsp) begin
         e.data = exp_data;
         e.cyc  = tcyc + 19 + rw;
         if (d == 0) sb0.push_back(e);
         else        sb1.push_back(e);
      end
      for (int k = 1; k <= last; k++) begin
         if (k > 1) @(negedge clk);
         chk($sformatf("ss_n%0d_k%0d", d, k), ss_n[d], is_rd ? (k >= 20 + rw) : (k >= 12));
         chk($sformatf("mosi%0d_k%0d", d, k), mosi[d], (k >= 2 && k <= 11) ? c[11-k] : 1'b0);
         chk($sformatf("ready%0d_k%0d", d, k), cmd_ready[d], k >= last);
         chk($sformatf("busy%0d_k%0d", d, k), busy[d], k < last);
         chk($sformatf("err%0d_k%0d", d, k), err[d], 1'b0);
         // slave model: reply MSB first over the sample window, idle high
         idx = k - (12 + rw);
         miso[d] = (is_rd && idx >= 0 && idx < 8) ? sb[7-idx] : 1'b1;
      end
      miso[d] = 1'b1;
   endtask

   vec_t tbl[9];
   int   nacc, a0, a1;

   initial begin
      tbl[0] = '{10'h0A5, 8'h00, 1'b0, 8'h00};
      tbl[1] = '{10'h155, 8'h00, 1'b0, 8'h00};
      tbl[2] = '{10'h210, 8'h00, 1'b0, 8'h00};
      tbl[3] = '{10'h300, 8'hC3, 1'b1, 8'hC3};
      tbl[4] = '{10'h2FF, 8'h00, 1'b0, 8'h00};
      tbl[5] = '{10'h35A, 8'h5A, 1'b1, 8'h5A};
      tbl[6] = '{10'h201, 8'h00, 1'b0, 8'h00};
      tbl[7] = '{10'h201, 8'h00, 1'b0, 8'h00};
      tbl[8] = '{10'h3FF, 8'h81, 1'b1, 8'h81};

      rst_n       = 1'b0;
      cmd_valid   = 2'b00;
      cmd_data[0] = '0;
      cmd_data[1] = '0;
      miso        = 2'b11;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ss_n", ss_n[d], 1'b1);
         chk("rst_mosi", mosi[d], 1'b0);
         chk("rst_ready", cmd_ready[d], 1'b1);
         chk("rst_rsp_valid", rsp_valid[d], 1'b0);
         chk("rst_rsp_data", rsp_data[d], 8'h00);
         chk("rst_busy", busy[d], 1'b0);
         chk("rst_err", err[d], 1'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // rd-data straight after reset, no rd-addr before it
`ifdef SPI_MASTER_ADDR_TRACK_EN
      cmd_valid[0] = 1'b1;
      cmd_data[0]  = 10'h3FF;
      wait_ready(0);
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      chk("orphan_err_pulse", err[0], 1'b1);
      chk("orphan_ss_n", ss_n[0], 1'b1);
      chk("orphan_ready", cmd_ready[0], 1'b1);
      chk("orphan_busy", busy[0], 1'b0);
      @(negedge clk);
      chk("orphan_err_clear", err[0], 1'b0);
      chk("orphan_ss_n2", ss_n[0], 1'b1);
`else
      check_frame(0, 10'h3FF, 8'h81, 1'b1, 8'h81, 2, 1);
`endif

      for (int i = 0; i < 9; i++)
         check_frame(0, tbl[i].cmd, tbl[i].miso_byte, tbl[i].exp_rsp, tbl[i].exp_data, 2, 1);

      // cmd_valid held across frames: one accept per frame, IDLE_GAP apart
      @(negedge clk);
      cmd_valid[0] = 1'b1;
      cmd_data[0]  = 10'h0A5;
      nacc = 0; a0 = -1; a1 = -1;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready[0]) begin
            if (nacc == 0) a0 = i;
            else           a1 = i;
            nacc++;
         end
         if (i == 5)  chk("hold_ss_low", ss_n[0], 1'b0);
         if (i == 12) chk("hold_ss_gap", ss_n[0], 1'b1);
         @(negedge clk);
      end
      cmd_valid[0] = 1'b0;
      chk("hold_accepts", nacc, 2);
      chk("hold_spacing", a1 - a0, 13);
      wait_ready(0);

      // reset during a rd-data frame
      check_frame(0, 10'h210, 8'h00, 1'b0, 8'h00, 2, 1);
      @(negedge clk);
      cmd_valid[0] = 1'b1;
      cmd_data[0]  = 10'h300;
      wait_ready(0);
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      repeat (5) @(negedge clk);
      chk("midrst_ss_before", ss_n[0], 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_ss_n", ss_n[0], 1'b1);
      chk("midrst_busy", busy[0], 1'b0);
      chk("midrst_ready", cmd_ready[0], 1'b1);
      chk("midrst_mosi", mosi[0], 1'b0);
      repeat (2) @(negedge clk);
      chk("midrst_rsp_valid", rsp_valid[0], 1'b0);
      chk("midrst_rsp_data", rsp_data[0], 8'h00);
      chk("midrst_err", err[0], 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_frame(0, 10'h210, 8'h00, 1'b0, 8'h00, 2, 1);
      check_frame(0, 10'h300, 8'h3C, 1'b1, 8'h3C, 2, 1);

      // overridden timing instance
      check_frame(1, 10'h210, 8'h00, 1'b0, 8'h00, 1, 3);
      check_frame(1, 10'h3C4, 8'h96, 1'b1, 8'h96, 1, 3);
      check_frame(1, 10'h155, 8'h00, 1'b0, 8'h00, 1, 3);

      repeat (3) @(negedge clk);
      chk("sb0_drained", sb0.size(), 0);
      chk("sb1_drained", sb1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_master.md
# spi_master

SPI master driving the 10-bit command/8-bit response frame protocol used by the RAM-bridge SPI slave. It accepts parallel commands on a valid/ready port and serialises them MSB-first on MOSI under SS_n. For read-data commands it samples the 8-bit reply from MISO and returns it on a response port. Master, slave and the test bench share one system clock; one bit is transferred per clk cycle, and no separate SCK is generated.

## Interface
- RD_WAIT, 2: number of clk cycles between the last MOSI bit and the first MISO sample on a read-data frame; legal range 1..15.
- IDLE_GAP, 1: minimum number of cycles SS_n stays high between frames; legal range 1..15.
- clk  in  1  system clock; all logic is clocked on the posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  the master can accept a command; high only in IDLE.
- cmd_data  in  10  frame to send; [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  8  byte received from MISO; held until the next rsp_valid.
- busy  out  1  a frame or gap is in progress.
- err  out  1  one-cycle pulse on a protocol violation (see Configuration).
- SS_n  out  1  slave select, active-low.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.

## Operation
- States: IDLE, LEAD, SHIFT, WAIT, READ, GAP.
- IDLE: SS_n=1, cmd_ready=1. When cmd_valid&&cmd_ready, latch cmd_data into a 10-bit shift register and go to LEAD.
- LEAD: SS_n=0 and MOSI=0 for 1 cycle. This gives the slave its IDLE->CHK_CMD cycle. Go to SHIFT.
- SHIFT: 10 cycles. MOSI = shreg[9], then shift left. After bit 0 the next state depends on the opcode: opcode 11 goes to WAIT; all other opcodes go to GAP.
- WAIT: RD_WAIT cycles with SS_n=0 and MOSI=0. Then go to READ.
- READ: 8 cycles. Sample MISO on each posedge into rx[7:0], MSB first. After the 8th sample, load rsp_data, pulse rsp_valid, and go to GAP.
- GAP: SS_n=1 for IDLE_GAP cycles. Then go to IDLE.
- busy = (state != IDLE).
- cmd_valid is ignored while cmd_ready=0. No queuing.
- Reset values: SS_n=1, MOSI=0, cmd_ready=1, rsp_valid=0, rsp_data=8'h00, busy=0, err=0. The state returns to IDLE.
- Reset mid-frame: SS_n rises asynchronously and the frame is abandoned. No rsp_valid or err is generated.

## Timing
- Cycle numbering: command accepted at edge T.
- T+1: SS_n=0 (LEAD).
- T+2..T+11: MOSI carries cmd_data[9]..cmd_data[0].
- Write and rd-addr frames: SS_n=1 from T+12, and cmd_ready=1 again at T+12+IDLE_GAP.
- Read-data frames:
  - MISO is sampled at edges T+12+RD_WAIT .. T+19+RD_WAIT.
  - rsp_valid=1 during the cycle after the last sample.
  - SS_n=1 in that same cycle.
  - cmd_ready=1 IDLE_GAP cycles later.
- All outputs are registered, except cmd_ready and busy, which are decoded from state.

## Configuration
- SPI_MASTER_ADDR_TRACK_EN defined:
  - The master keeps a flag addr_pending, set by an accepted opcode 10 and cleared by an accepted opcode 11.
  - An opcode-11 command accepted with addr_pending=0 is consumed (cmd_ready handshake completes) but not transmitted.
  - err pulses for 1 cycle at T+1, and the state stays IDLE.
  - A second opcode 10 while addr_pending=1 is transmitted normally.
  - Reset clears addr_pending.
- Undefined: every opcode is transmitted unconditionally, and err is tied to 0.

## Structure
- Package spi_pkg contains:
  - Opcode localparams OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA.
  - FRAME_W=10 and DATA_W=8.
  - The state encoding typedef.
- Sub-module spi_master_shreg: parallel-load / serial-out 10-bit shift register plus serial-in 8-bit capture register, with load, shift and capture enables. The FSM and counters stay in spi_master.

## Test plan
- Reset, then a wr-addr command 10'h0A5 -> SS_n low for T+1..T+11; MOSI bits 0,0,1,0,1,0,0,1,0,1 over T+2..T+11; cmd_ready returns after the gap; no rsp_valid.
- Rd-addr 10'h210 followed by rd-data 10'h300, with the bench slave model driving 8'hC3 → a single rsp_valid pulse with rsp_data=8'hC3 at the cycle computed from RD_WAIT=2.
- cmd_valid held high across a busy frame → exactly one accept per frame; the second command starts only after IDLE_GAP.
- rst_n asserted at T+6 of a rd-data frame → SS_n=1 immediately, no rsp_valid, clean frame after release.
- With SPI_MASTER_ADDR_TRACK_EN, rd-data 10'h3FF issued right after reset → err pulse, SS_n stays 1.
- Without SPI_MASTER_ADDR_TRACK_EN, rd-data 10'h3FF issued right after reset → frame transmitted, err=0.
- RD_WAIT=1 and IDLE_GAP=3 overrides → MISO sampled at T+13..T+20; SS_n high for 3 cycles after the frame.
